// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch controller.
package fetch_pkg;

  localparam int PC_W    = 64;
  localparam int IMEM_AW = 6;
  localparam int INSTR_W = 32;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry queue of fetched {instr, pc} pairs with flush; full + pop accepts a push.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int W = $bits(fetch_entry_t)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // When full, wr_ptr equals rd_ptr: the head is read this cycle and replaced at the edge.
  always_ff @(posedge clk) begin
    if (!reset && !flush && do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequential PC fetch from a small ROM into a 2-deep queue.
//   state | meaning
//   RUN   | fetching at pc, accepting redirects
//   FAULT | pc misaligned or out of ROM range; fetch stopped until reset
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                  N        = 32,
  parameter int                  PC_W     = fetch_pkg::PC_W,
  parameter logic [PC_W-1:0]     RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [N-1:0]       imem_q,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [N-1:0]       instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               fault
);

  fetch_state_t      state, state_nxt;
  logic [PC_W-1:0]   pc, pc_nxt;
  logic [1:0]        count;
  logic              push;
  logic              pop;
  logic              flush;
  logic              pc_bad;
  logic [N+PC_W-1:0] head;

  assign imem_addr   = pc[IMEM_AW+1:2];
  assign pc_bad      = (pc[1:0] != 2'b00) || (pc[PC_W-1:8] != '0);
  assign instr_valid = !reset && (count != 2'd0);
  assign pop         = instr_valid && instr_ready;
  assign instr       = head[N+PC_W-1:PC_W];
  assign instr_pc    = head[PC_W-1:0];

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    push      = 1'b0;
    flush     = 1'b0;
    case (state)
      RUN: begin
        if (redirect_valid) begin
          flush  = 1'b1;
          pc_nxt = redirect_pc;
        end else if (pc_bad) begin
          state_nxt = FAULT;
        end else if ((count != 2'd2) || pop) begin
          push   = 1'b1;
          pc_nxt = pc + PC_W'(4);
        end
      end
      FAULT: begin
        state_nxt = FAULT;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      pc    <= RESET_PC;
      fault <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      fault <= fault || (state_nxt == FAULT);
    end
  end

  fetch_fifo #(
    .W(N + PC_W)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .flush(flush),
    .push (push),
    .pop  (pop),
    .din  ({imem_q, pc}),
    .dout (head),
    .count(count)
  );

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter N, default 32, instruction word width.
REQ-002 SHALL have parameter PC_W, default 64, program-counter width.
REQ-003 SHALL have parameter RESET_PC, default 0, byte address fetched first after reset.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port imem_addr, output, 6, word address to the instruction ROM.
REQ-007 SHALL have port imem_q, input, N, ROM data; combinational, valid in the same cycle as imem_addr.
REQ-008 SHALL have port redirect_valid, input, 1, taken branch or jump from the core.
REQ-009 SHALL have port redirect_pc, input, PC_W, target byte address.
REQ-010 SHALL have port instr_valid, output, 1, queue head valid.
REQ-011 SHALL have port instr_ready, input, 1, core accepts the head.
REQ-012 SHALL have port instr, output, N, head instruction word.
REQ-013 SHALL have port instr_pc, output, PC_W, byte address of the head.
REQ-014 SHALL have port fault, output, 1, sticky fetch fault (misaligned or out-of-range PC).

Function
REQ-015 SHALL hold fetch PC register pc and a 2-entry FIFO of {instr, pc} pairs.
REQ-016 SHALL drive imem_addr = pc[7:2] combinationally every cycle.
REQ-017 SHALL define pop = instr_valid && instr_ready.
REQ-018 SHALL define push = state RUN && !redirect_valid && (count < 2 || pop).
REQ-019 On push, SHALL write {imem_q, pc} at the tail and set pc <= pc + 4, with modulo 2^PC_W wrap.
REQ-020 SHALL drive instr_valid = (count != 0), with instr/instr_pc taken from the head; head data stays stable while instr_valid && !instr_ready.
REQ-021 Simultaneous push and pop SHALL leave count unchanged; full FIFO with pop SHALL accept a push in the same cycle.
REQ-022 Fetch-to-instr_valid latency SHALL be 1 cycle; sustained throughput SHALL be 1 instruction/cycle while instr_ready is held at 1.
REQ-023 redirect_valid SHALL have priority: flush the FIFO (count <= 0), set pc <= redirect_pc, no push that cycle; a head popped in that cycle counts as consumed.
REQ-024 Next fetch after a redirect SHALL occur the following cycle, so the target appears on instr 2 cycles after redirect_valid.
REQ-025 State machine SHALL have states RUN and FAULT, with transition RUN->FAULT when the pc to be fetched has pc[1:0] != 0 or pc[PC_W-1:8] != 0.
REQ-026 On entering FAULT, SHALL set fault <= 1 and stop pushes; existing FIFO entries still drain.
REQ-027 In FAULT, only reset SHALL leave; redirect_valid SHALL be ignored.
REQ-028 A redirect to a faulting target SHALL enter FAULT on the next cycle's fault check.

Reset
REQ-029 On reset=1 at a clock edge, SHALL set pc <= RESET_PC, count <= 0, state <= RUN, fault <= 0, all FIFO pointers <= 0.
REQ-030 While reset=1, instr_valid SHALL be 0; imem_addr SHALL be RESET_PC[7:2] from the cycle after the first reset edge.
REQ-031 Reset asserted mid-stream SHALL discard queued entries with no pop visible after the reset edge.

Structure
REQ-032 Package fetch_pkg SHALL hold PC_W and IMEM_AW=6 constants, the fetch_state_t enum {RUN, FAULT}, and the fetch_entry_t struct {instr, pc}.
REQ-033 SHALL instantiate one sub-module, fetch_fifo: 2-entry, flush input, push/pop, count output.

Verification
REQ-034 Bench SHALL use a ROM model returning word = {26'b0, addr} and hold instr_ready=1 from reset release: instr SHALL be 0,1,2,3 with instr_pc 0x0,0x4,0x8,0xC on consecutive cycles, first valid 1 cycle after reset release.
REQ-035 Bench SHALL hold instr_ready=0 for 5 cycles: count saturates at 2, instr stays 0 / pc 0x0, imem_addr parks at 2; on ready=1, 0,1,2 SHALL stream with no gap.
REQ-036 Bench SHALL apply redirect_valid with redirect_pc=0x40 while the FIFO is full: queued entries flushed, instr=16 with instr_pc=0x40 exactly 2 cycles later.
REQ-037 Bench SHALL apply redirect_pc=0x42: fault=1 next cycle, no further pushes, existing entries drain, a later redirect to 0x0 is ignored.
REQ-038 Bench SHALL apply redirect_pc=0x100: fault=1; reset then SHALL restart fetch at 0x0 with fault=0.
REQ-039 Bench SHALL assert reset with 2 entries queued and ready=0: instr_valid SHALL be 0 on the next cycle, and fetch SHALL resume at RESET_PC after release.
